// File: rtl/filter_sched.sv
`timescale 1ns / 1ps
// Sequencing controller for the filter core: sample-rate strobes, switch debounce and the
// drain/clear/settle sequence that keeps a half-filled filter off the output mux.
module filter_sched #(
  parameter int unsigned FG_DIV     = 100,
  parameter int unsigned FIR_DIV    = 5000,
  parameter int unsigned IIR_DIV    = 2500,
  parameter int unsigned DEB_CYC    = 1000000,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_SMP = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode_req,
  output logic       fg_stb,
  output logic       fir_stb,
  output logic       iir_stb,
  output logic       lpf_en,
  output logic       hpf_en,
  output logic       bpf_en,
  output logic       flt_clr,
  output logic [2:0] mode_cur,
  output logic       out_valid,
  output logic       busy
);

  localparam int unsigned FgW  = $clog2(FG_DIV + 1);
  localparam int unsigned FirW = $clog2(FIR_DIV + 1);
  localparam int unsigned IirW = $clog2(IIR_DIV + 1);
  localparam int unsigned DebW = $clog2(DEB_CYC + 1);
  localparam int unsigned ClrW = $clog2(CLR_CYC + 1);
  localparam int unsigned SmpW = $clog2(SETTLE_SMP + 1);

  typedef enum logic [2:0] {StIdle, StDrain, StClear, StSettle, StRun} state_e;

  logic [FgW-1:0]  fg_cnt_q, fg_cnt_d;
  logic [FirW-1:0] fir_cnt_q, fir_cnt_d;
  logic [IirW-1:0] iir_cnt_q, iir_cnt_d;
  logic            fg_stb_q, fir_stb_q, iir_stb_q;

  // Strobe flops are loaded from the next count so each pulse lines up with count == DIV-1.
  always_comb begin
    fg_cnt_d  = (fg_cnt_q == FgW'(FG_DIV - 1)) ? '0 : fg_cnt_q + 1'b1;
    fir_cnt_d = (fir_cnt_q == FirW'(FIR_DIV - 1)) ? '0 : fir_cnt_q + 1'b1;
    iir_cnt_d = (iir_cnt_q == IirW'(IIR_DIV - 1)) ? '0 : iir_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fg_cnt_q  <= '0;
      fir_cnt_q <= '0;
      iir_cnt_q <= '0;
      fg_stb_q  <= 1'b0;
      fir_stb_q <= 1'b0;
      iir_stb_q <= 1'b0;
    end else begin
      fg_cnt_q  <= fg_cnt_d;
      fir_cnt_q <= fir_cnt_d;
      iir_cnt_q <= iir_cnt_d;
      fg_stb_q  <= (fg_cnt_d == FgW'(FG_DIV - 1));
      fir_stb_q <= (fir_cnt_d == FirW'(FIR_DIV - 1));
      iir_stb_q <= (iir_cnt_d == IirW'(IIR_DIV - 1));
    end
  end

  logic [2:0]      sync1_q, sync2_q, deb_val_q;
  logic [DebW-1:0] deb_cnt_q;

  // Debounce count saturates one past DEB_CYC-1 so a stable value is accepted only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_val_q <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= mode_req;
      sync2_q <= sync1_q;
      if (sync2_q != deb_val_q) begin
        deb_val_q <= sync2_q;
        deb_cnt_q <= '0;
      end else if (deb_cnt_q != DebW'(DEB_CYC)) begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  state_e          state_q, state_d;
  logic [2:0]      tgt_q, tgt_d, mode_cur_q, mode_cur_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [SmpW-1:0] smp_cnt_q, smp_cnt_d;
  logic            lpf_en_q, hpf_en_q, bpf_en_q, flt_clr_q, out_valid_q, busy_q;
  logic            lpf_en_d, hpf_en_d, bpf_en_d, flt_clr_d, out_valid_d, busy_d;
  logic            accept, code_ok, go_idle, go_drain, sel_stb, enabled;

  always_comb begin
    accept = (sync2_q == deb_val_q) && (deb_cnt_q == DebW'(DEB_CYC - 1));
    case (deb_val_q)
      3'b001, 3'b010, 3'b100: code_ok = 1'b1;
      default:                code_ok = 1'b0;
    endcase
    go_idle  = accept && (deb_val_q == 3'b000) && (state_q != StIdle);
    go_drain = accept && code_ok && (deb_val_q != mode_cur_q) && (state_q != StDrain);
    sel_stb  = (mode_cur_q == 3'b100) ? iir_stb_q : fir_stb_q;
  end

  // Mode acceptance is checked ahead of the state case, so it beats a coincident final strobe.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    mode_cur_d = mode_cur_q;
    clr_cnt_d  = clr_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    if (go_idle) begin
      state_d    = StIdle;
      mode_cur_d = 3'b000;
    end else if (go_drain) begin
      state_d   = StDrain;
      tgt_d     = deb_val_q;
      smp_cnt_d = '0;
    end else begin
      case (state_q)
        StDrain: begin
          state_d    = StClear;
          mode_cur_d = tgt_q;
          clr_cnt_d  = '0;
        end
        StClear: begin
          if (clr_cnt_q == ClrW'(CLR_CYC - 1)) begin
            state_d   = StSettle;
            smp_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (sel_stb) begin
            if (smp_cnt_q == SmpW'(SETTLE_SMP - 1)) state_d = StRun;
            else smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    enabled     = (state_d == StSettle) || (state_d == StRun);
    lpf_en_d    = enabled && (mode_cur_d == 3'b001);
    hpf_en_d    = enabled && (mode_cur_d == 3'b010);
    bpf_en_d    = enabled && (mode_cur_d == 3'b100);
    flt_clr_d   = (state_d == StClear);
    out_valid_d = (state_d == StRun);
    busy_d      = (state_d == StDrain) || (state_d == StClear) || (state_d == StSettle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      tgt_q       <= '0;
      mode_cur_q  <= '0;
      clr_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      lpf_en_q    <= 1'b0;
      hpf_en_q    <= 1'b0;
      bpf_en_q    <= 1'b0;
      flt_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      mode_cur_q  <= mode_cur_d;
      clr_cnt_q   <= clr_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      lpf_en_q    <= lpf_en_d;
      hpf_en_q    <= hpf_en_d;
      bpf_en_q    <= bpf_en_d;
      flt_clr_q   <= flt_clr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign fg_stb    = fg_stb_q;
  assign fir_stb   = fir_stb_q;
  assign iir_stb   = iir_stb_q;
  assign lpf_en    = lpf_en_q;
  assign hpf_en    = hpf_en_q;
  assign bpf_en    = bpf_en_q;
  assign flt_clr   = flt_clr_q;
  assign mode_cur  = mode_cur_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_filter_sched.sv
`timescale 1ns / 1ps
// Bench for filter_sched: expected output changes are queued with their cycle by the stimulus,
// a monitor pops and compares on every output change and checks strobe timing each cycle.
module tb_filter_sched;

  localparam int FG  = 10;
  localparam int FIR = 50;
  localparam int IIR = 25;
  localparam int DEB = 200;
  localparam int CLR = 4;
  localparam int SMP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode_req = 3'b000;
  logic       fg_stb, fir_stb, iir_stb, lpf_en, hpf_en, bpf_en, flt_clr, out_valid, busy;
  logic [2:0] mode_cur;

  filter_sched #(
    .FG_DIV    (FG),
    .FIR_DIV   (FIR),
    .IIR_DIV   (IIR),
    .DEB_CYC   (DEB),
    .CLR_CYC   (CLR),
    .SETTLE_SMP(SMP)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .mode_req (mode_req),
    .fg_stb   (fg_stb),
    .fir_stb  (fir_stb),
    .iir_stb  (iir_stb),
    .lpf_en   (lpf_en),
    .hpf_en   (hpf_en),
    .bpf_en   (bpf_en),
    .flt_clr  (flt_clr),
    .mode_cur (mode_cur),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycles since reset release: after the k-th rising edge, cyc == k.
  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [8:0] outs;
  } ev_t;
  ev_t        q[$];
  ev_t        ev;
  logic [8:0] outs;
  logic [8:0] prev_outs = 9'h000;

  assign outs = {mode_cur, lpf_en, hpf_en, bpf_en, flt_clr, out_valid, busy};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] en_of(input logic [2:0] m);
    return {m == 3'b001, m == 3'b010, m == 3'b100};
  endfunction

  function automatic logic [8:0] pk(input logic [2:0] m, input logic [2:0] en,
                                    input logic c, input logic v, input logic b);
    return {m, en, c, v, b};
  endfunction

  // Cycle of the n-th strobe (period div) at or after cycle start.
  function automatic int nth_stb(input int start, input int div, input int n);
    return start + (div - 1 - (start % div)) + (n - 1) * div;
  endfunction

  task automatic push(input int c, input logic [8:0] o);
    q.push_back('{cyc: c, outs: o});
  endtask

  // Switch edit after cycle e: 3-cycle sync/latch plus DEB cycles of stability, then the sequence.
  task automatic push_seq(input int e, input logic [2:0] om, input logic [2:0] nm,
                          input int div, input bit to_run);
    int a;
    a = e + DEB + 3;
    push(a, pk(om, 3'b000, 1'b0, 1'b0, 1'b1));
    push(a + 1, pk(nm, 3'b000, 1'b1, 1'b0, 1'b1));
    push(a + 1 + CLR, pk(nm, en_of(nm), 1'b0, 1'b0, 1'b1));
    if (to_run) push(nth_stb(a + 1 + CLR, div, SMP) + 1, pk(nm, en_of(nm), 1'b0, 1'b1, 1'b0));
  endtask

  always @(negedge clk) begin
    if (fg_stb || (cyc % FG) == FG - 1) chk("fg_stb", 32'(fg_stb), 32'((cyc % FG) == FG - 1));
    if (fir_stb || (cyc % FIR) == FIR - 1)
      chk("fir_stb", 32'(fir_stb), 32'((cyc % FIR) == FIR - 1));
    if (iir_stb || (cyc % IIR) == IIR - 1)
      chk("iir_stb", 32'(iir_stb), 32'((cyc % IIR) == IIR - 1));
    if (outs !== prev_outs) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: got %h expected %h (no change) at cyc %0d",
                 outs, prev_outs, cyc);
      end else begin
        ev = q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(ev.cyc));
        chk("event_outputs", 32'(outs), 32'(ev.outs));
      end
    end
    prev_outs = outs;
  end

  task automatic drive(input logic [2:0] v, output int e);
    @(negedge clk);
    #1;
    mode_req = v;
    e = cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, a, k10;
    #1 rst = 1'b0;
    #7;
    chk("in_reset_outputs", 32'(outs), 32'd0);
    chk("in_reset_strobes", 32'({fg_stb, fir_stb, iir_stb}), 32'd0);
    #14 rst = 1'b1;

    // Idle after reset: strobe timing checked by the monitor, no output changes expected.
    wait_until(3 * FIR + 5);
    chk("idle_outputs", 32'(outs), 32'd0);

    // LPF from idle.
    drive(3'b001, e);
    push_seq(e, 3'b000, 3'b001, FIR, 1'b1);
    wait_drain("lpf_seq_done");
    chk("lpf_run", 32'(outs), 32'(pk(3'b001, 3'b100, 1'b0, 1'b1, 1'b0)));

    // LPF run -> BPF, settle counted on iir_stb.
    drive(3'b100, e);
    push_seq(e, 3'b001, 3'b100, IIR, 1'b1);
    wait_drain("bpf_seq_done");
    chk("bpf_run", 32'(outs), 32'(pk(3'b100, 3'b001, 1'b0, 1'b1, 1'b0)));

    drive(3'b000, e);
    push(e + DEB + 3, 9'h000);
    wait_drain("off_from_run");

    // Bouncing switch: no acceptance until 010 is held.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 3'b010 : 3'b000, e);
      wait_until(e + 50);
    end
    drive(3'b010, e);
    push_seq(e, 3'b000, 3'b010, FIR, 1'b1);
    wait_drain("hpf_seq_done");
    chk("hpf_run", 32'(outs), 32'(pk(3'b010, 3'b010, 1'b0, 1'b1, 1'b0)));

    drive(3'b000, e);
    push(e + DEB + 3, 9'h000);
    wait_drain("off_from_hpf");

    // HPF settle interrupted after 10 strobes by an off request.
    drive(3'b010, e);
    push_seq(e, 3'b000, 3'b010, FIR, 1'b0);
    a = e + DEB + 3;
    k10 = nth_stb(a + 1 + CLR, FIR, 10);
    wait_until(k10);
    chk("settle_busy", 32'(outs), 32'(pk(3'b010, 3'b010, 1'b0, 1'b0, 1'b1)));
    drive(3'b000, e2);
    push(e2 + DEB + 3, 9'h000);
    wait_drain("off_from_settle");
    chk("idle_after_settle", 32'(outs), 32'd0);

    // Invalid code is never accepted.
    drive(3'b111, e);
    wait_until(e + DEB + 40);
    chk("invalid_ignored", 32'(outs), 32'd0);

    // Reset during CLEAR.
    drive(3'b001, e);
    a = e + DEB + 3;
    push(a, pk(3'b000, 3'b000, 1'b0, 1'b0, 1'b1));
    push(a + 1, pk(3'b001, 3'b000, 1'b1, 1'b0, 1'b1));
    wait_until(a + 2);
    chk("clear_active", 32'(flt_clr), 32'd1);
    mode_req = 3'b000;
    push(0, 9'h000);
    #2 rst = 1'b0;
    #1;
    chk("reset_clears_outputs", 32'(outs), 32'd0);
    chk("reset_clears_strobes", 32'({fg_stb, fir_stb, iir_stb}), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wait_until(2 * FIR + 5);
    chk("idle_after_reset", 32'(outs), 32'd0);
    wait_drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_sched.md
Name: filter_sched

Overview:
Sequencing controller for the filter core. Generates the three sample-rate strobes (function generator, FIR, IIR) from the system clock. Debounces the raw mode switches and enables exactly one filter at a time. On every mode change it runs a drain/clear/settle sequence, so the output mux never forwards a half-filled filter's output.

Parameters:
FG_DIV, 100, clk cycles per function-generator strobe (1 MHz at 100 MHz clk)
FIR_DIV, 5000, clk cycles per FIR strobe (20 kHz)
IIR_DIV, 2500, clk cycles per IIR strobe (40 kHz)
DEB_CYC, 1000000, cycles a new switch value must stay stable before acceptance (10 ms)
CLR_CYC, 4, cycles flt_clr is held high
SETTLE_SMP, 32, sample strobes of the selected filter's rate to wait before out_valid

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
mode_req  in  3  raw switch code: 000 off, 001 LPF, 010 HPF, 100 BPF; other codes invalid
fg_stb  out  1  1-cycle pulse every FG_DIV cycles
fir_stb  out  1  1-cycle pulse every FIR_DIV cycles
iir_stb  out  1  1-cycle pulse every IIR_DIV cycles
lpf_en  out  1  LPF enable
hpf_en  out  1  HPF enable
bpf_en  out  1  BPF enable
flt_clr  out  1  clear filter delay lines/accumulators
mode_cur  out  3  accepted mode driving the output mux (encoding as mode_req)
out_valid  out  1  selected filter's output is settled; downstream forces output to 0 when low
busy  out  1  high in DRAIN, CLEAR and SETTLE

Behaviour:
- Reset (rst low, asynchronous): all counters 0, state IDLE, every output 0, mode_cur = 000.
- Strobes: each strobe has a free-running counter 0..DIV-1, registered. The strobe is high for exactly the cycle in which its counter equals DIV-1. The first pulse appears DIV cycles after rst deasserts. Strobes are never gated by the state machine.
- Synchroniser: mode_req passes through a 2-flop synchroniser (2-cycle latency).
- Debounce counter: clears whenever the synchronised value differs from the previous cycle. The value is accepted when the counter reaches DEB_CYC-1 with the value unchanged.
- Invalid codes (011, 101, 110, 111) are never accepted. Current state is kept.
- An accepted code equal to mode_cur causes no action.
- FSM states: IDLE, DRAIN, CLEAR, SETTLE, RUN.
  - IDLE: all enables 0, out_valid 0. Accepted nonzero code -> DRAIN.
  - DRAIN: 1 cycle. All enables 0, out_valid 0. Latch target into mode_cur -> CLEAR.
  - CLEAR: flt_clr = 1 for CLR_CYC cycles, enables 0 -> SETTLE.
  - SETTLE: enable the one filter selected by mode_cur. Count strobes of its rate: fir_stb for LPF/HPF, iir_stb for BPF. After SETTLE_SMP strobes -> RUN.
  - RUN: out_valid = 1, enable held.
- Mode changes:
  - Accepted new nonzero code in CLEAR, SETTLE or RUN -> DRAIN immediately. The settle count restarts; out_valid drops in the cycle DRAIN is entered.
  - Accepted 000 from any state -> IDLE next cycle. mode_cur = 000, flt_clr 0.
- Timing rules:
  - If the counted strobe and the final-count condition coincide in the same cycle as a mode acceptance, the mode change wins.
  - At most one enable is high in any cycle, and never while flt_clr = 1.
  - Every FSM output is registered; each output changes on the clock edge of its state transition.
- rst asserted mid-sequence returns everything to reset values immediately. The sequence does not resume after reset.

Test Plan:
1. Reset release, no switch activity -> fg_stb first at cycle 100, then every 100 cycles. fir_stb at 5000, 10000. iir_stb at 2500, 5000. All enables 0, out_valid 0.
2. mode_req = 001 held stable -> acceptance 2+DEB_CYC cycles later. Then 1 cycle DRAIN, 4 cycles flt_clr, then lpf_en = 1. out_valid rises the cycle after the 32nd fir_stb; mode_cur = 001.
3. Bounce: toggle mode_req 000/010 every 500 cycles for 5 ms, then hold 010 -> no acceptance during bouncing. Exactly one sequence runs, ending with hpf_en = 1 and out_valid = 1.
4. In RUN with LPF, change to 100 -> out_valid drops at DRAIN, then lpf_en falls and flt_clr pulses for 4 cycles. bpf_en rises; out_valid returns after 32 iir_stb (about 80000 cycles).
5. In SETTLE with HPF after 10 strobes, switch to 000 -> next cycle IDLE, all enables 0, mode_cur = 000. Then apply 111 -> ignored, stays IDLE.
6. Assert rst during CLEAR -> flt_clr, enables and counters are 0 immediately. After release, the first strobes are at DIV cycles and the FSM is in IDLE.
